// File: rtl/pc_sequencer.sv
// Next-PC controller: picks the PC register's next value from the sequential,
// branch, jump, interrupt-vector and exception-return sources, and handles stall and halt.
module pc_sequencer #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0,
   parameter logic [WIDTH-1:0] ISR_BASE = 32'h0000_0800
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [WIDTH-1:0] branch_target,
   input  logic             jump,
   input  logic [WIDTH-1:0] jump_target,
   input  logic             halt_req,
   input  logic             go,
   input  logic [2:0]       irq,
   input  logic             eret,
   output logic [WIDTH-1:0] pc_next,
   output logic             pc_en,
   output logic             flush,
   output logic [WIDTH-1:0] epc,
   output logic             in_isr,
   output logic [1:0]       isr_src,
   output logic             halted
);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t           state_q, state_d;
   logic [2:0]       pending_q, pending_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic             in_isr_q, in_isr_d;
   logic [1:0]       isr_src_q, isr_src_d;

   logic [WIDTH-1:0] seq;
   logic [WIDTH-1:0] ret;
   logic [1:0]       src_sel;
   logic [2:0]       clr;

   always_comb begin
      seq = pc + WIDTH'(4);
      ret = jump ? jump_target : (branch_taken ? branch_target : seq);

      // Lowest set bit wins; only meaningful when pending_q is non-zero.
      if (pending_q[0])      src_sel = 2'd0;
      else if (pending_q[1]) src_sel = 2'd1;
      else                   src_sel = 2'd2;

      state_d   = state_q;
      epc_d     = epc_q;
      in_isr_d  = in_isr_q;
      isr_src_d = isr_src_q;
      clr       = 3'b000;
      pc_next   = pc;
      pc_en     = 1'b0;
      flush     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (stall) begin
               pc_next = pc;
            end else if (halt_req) begin
               state_d = ST_HALT;
            end else if (!in_isr_q && (pending_q != 3'b000)) begin
               pc_next      = ISR_BASE + (WIDTH'(src_sel) << 4);
               pc_en        = 1'b1;
               flush        = 1'b1;
               epc_d        = ret;
               in_isr_d     = 1'b1;
               isr_src_d    = src_sel;
               clr[src_sel] = 1'b1;
            end else if (eret && in_isr_q) begin
               pc_next  = epc_q;
               pc_en    = 1'b1;
               flush    = 1'b1;
               in_isr_d = 1'b0;
            end else begin
               pc_next = ret;
               pc_en   = 1'b1;
               flush   = jump | branch_taken;
            end
         end
         ST_HALT: begin
            if (go) begin
               pc_next = seq;
               pc_en   = 1'b1;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase

      // A request arriving on the bit being cleared survives.
      pending_d = (pending_q & ~clr) | irq;

      if (rst) begin
         pc_next = RESET_PC;
         pc_en   = 1'b0;
         flush   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         pending_q <= 3'b000;
         epc_q     <= '0;
         in_isr_q  <= 1'b0;
         isr_src_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         epc_q     <= epc_d;
         in_isr_q  <= in_isr_d;
         isr_src_q <= isr_src_d;
      end
   end

   assign epc     = epc_q;
   assign in_isr  = in_isr_q;
   assign isr_src = isr_src_q;
   assign halted  = (state_q == ST_HALT) && !rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus a randomized run checked
// against a rule-level reference model.
module tb_pc_sequencer;

   localparam logic [31:0] ISR = 32'h0000_0800;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0, branch_target = '0, jump_target = '0;
   logic        stall = 0, branch_taken = 0, jump = 0, halt_req = 0, go = 0, eret = 0;
   logic [2:0]  irq = '0;
   logic [31:0] pc_next, epc;
   logic        pc_en, flush, in_isr, halted;
   logic [1:0]  isr_src;

   int n_cmp = 0;
   int n_bad = 0;

   pc_sequencer #(.WIDTH(32), .RESET_PC(32'h0), .ISR_BASE(ISR)) dut (
      .clk(clk), .rst(rst), .pc(pc), .stall(stall),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .jump(jump), .jump_target(jump_target), .halt_req(halt_req), .go(go),
      .irq(irq), .eret(eret), .pc_next(pc_next), .pc_en(pc_en), .flush(flush),
      .epc(epc), .in_isr(in_isr), .isr_src(isr_src), .halted(halted)
   );

   always #5 clk = ~clk;

   // Reference model: architectural state kept as plain variables.
   bit          m_halted, m_in_isr;
   bit [2:0]    m_pend;
   logic [31:0] m_epc, m_nat;
   int          m_src, m_take, m_act;
   logic [31:0] exp_next;
   bit          exp_en, exp_fl, exp_next_chk;

   function automatic void model_reset();
      m_halted = 0; m_in_isr = 0; m_pend = '0; m_epc = '0; m_src = 0;
   endfunction

   // m_act: 0 hold, 1 enter halt, 2 take interrupt, 3 return, 4 normal flow, 5 resume
   function automatic void model_eval();
      logic [31:0] seq;
      seq   = pc + 32'd4;
      m_nat = jump ? jump_target : (branch_taken ? branch_target : seq);
      exp_next = pc; exp_en = 0; exp_fl = 0; exp_next_chk = 1; m_act = 0; m_take = -1;
      for (int b = 2; b >= 0; b--) if (m_pend[b]) m_take = b;
      if (rst) begin
         exp_next = 32'h0;
      end else if (m_halted) begin
         if (go) begin exp_next = seq; exp_en = 1; m_act = 5; end
      end else if (stall) begin
         m_act = 0;
      end else if (halt_req) begin
         exp_next_chk = 0; m_act = 1;
      end else if (!m_in_isr && m_take >= 0) begin
         exp_next = ISR + 32'(m_take * 16); exp_en = 1; exp_fl = 1; m_act = 2;
      end else if (eret && m_in_isr) begin
         exp_next = m_epc; exp_en = 1; exp_fl = 1; m_act = 3;
      end else begin
         exp_next = m_nat; exp_en = 1; exp_fl = jump || branch_taken; m_act = 4;
      end
   endfunction

   function automatic void model_step();
      model_eval();
      if (rst) begin
         model_reset();
      end else begin
         case (m_act)
            1: m_halted = 1;
            2: begin m_epc = m_nat; m_in_isr = 1; m_src = m_take; m_pend[m_take] = 0; end
            3: m_in_isr = 0;
            5: m_halted = 0;
            default: ;
         endcase
         m_pend = m_pend | irq;
      end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else model_step();
   end

   task automatic idle_inputs();
      stall = 0; branch_taken = 0; jump = 0; halt_req = 0; go = 0; eret = 0; irq = '0;
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1; idle_inputs(); pc = 32'h0; #1;
      n_cmp++; if (pc_en !== 1'b0) begin n_bad++; $display("FAIL rst_en: got %b want 0", pc_en); end
      n_cmp++; if (pc_next !== 32'h0) begin n_bad++; $display("FAIL rst_next: got %h want 0", pc_next); end
      n_cmp++; if (flush !== 1'b0 || halted !== 1'b0) begin n_bad++; $display("FAIL rst_flush_halt: got %b%b want 00", flush, halted); end
      n_cmp++; if (in_isr !== 1'b0 || epc !== 32'h0 || isr_src !== 2'd0) begin n_bad++; $display("FAIL rst_isr: got %b %h %0d want 0 0 0", in_isr, epc, isr_src); end
      #1 rst = 0; #1;
      n_cmp++; if (pc_next !== 32'h4 || pc_en !== 1'b1 || flush !== 1'b0) begin n_bad++; $display("FAIL run_seq: got %h en%b fl%b want 4 en1 fl0", pc_next, pc_en, flush); end
      $display("test_reset done");
   endtask

   task automatic test_redirect();
      @(negedge clk); idle_inputs(); pc = 32'h100;
      jump = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300; #1;
      n_cmp++; if (pc_next !== 32'h200 || flush !== 1'b1 || pc_en !== 1'b1) begin n_bad++; $display("FAIL jump_over_branch: got %h fl%b want 200 fl1", pc_next, flush); end
      jump = 0; #1;
      n_cmp++; if (pc_next !== 32'h300 || flush !== 1'b1) begin n_bad++; $display("FAIL branch: got %h fl%b want 300 fl1", pc_next, flush); end
      jump = 1; stall = 1; #1;
      n_cmp++; if (pc_en !== 1'b0 || flush !== 1'b0 || pc_next !== 32'h100) begin n_bad++; $display("FAIL stall: got %h en%b fl%b want 100 en0 fl0", pc_next, pc_en, flush); end
      @(negedge clk); idle_inputs(); pc = 32'hFFFF_FFFC; #1;
      n_cmp++; if (pc_next !== 32'h0 || pc_en !== 1'b1) begin n_bad++; $display("FAIL wrap: got %h want 0", pc_next); end
      $display("test_redirect done");
   endtask

   task automatic test_irq();
      @(negedge clk); idle_inputs(); pc = 32'h40; irq = 3'b110; #1;
      n_cmp++; if (pc_next !== 32'h44 || flush !== 1'b0) begin n_bad++; $display("FAIL irq_same_cycle: got %h want 44", pc_next); end
      @(negedge clk); irq = 3'b000; #1;
      n_cmp++; if (pc_next !== 32'h810 || flush !== 1'b1 || pc_en !== 1'b1) begin n_bad++; $display("FAIL irq_vec1: got %h fl%b want 810 fl1", pc_next, flush); end
      @(negedge clk); pc = 32'h810; #1;
      n_cmp++; if (epc !== 32'h44 || isr_src !== 2'd1 || in_isr !== 1'b1) begin n_bad++; $display("FAIL irq_state: got %h %0d %b want 44 1 1", epc, isr_src, in_isr); end
      n_cmp++; if (pc_next !== 32'h814 || flush !== 1'b0) begin n_bad++; $display("FAIL no_nest: got %h want 814", pc_next); end
      eret = 1; #1;
      n_cmp++; if (pc_next !== 32'h44 || flush !== 1'b1) begin n_bad++; $display("FAIL eret: got %h want 44", pc_next); end
      @(negedge clk); eret = 0; pc = 32'h44; #1;
      n_cmp++; if (in_isr !== 1'b0 || pc_next !== 32'h820) begin n_bad++; $display("FAIL irq_vec2: got %b %h want 0 820", in_isr, pc_next); end
      @(negedge clk); pc = 32'h820; #1;
      n_cmp++; if (isr_src !== 2'd2 || epc !== 32'h48 || in_isr !== 1'b1) begin n_bad++; $display("FAIL irq_state2: got %0d %h %b want 2 48 1", isr_src, epc, in_isr); end
      @(negedge clk); pc = 32'h90; eret = 0; #1;
      n_cmp++; if (pc_next !== 32'h94) begin n_bad++; $display("FAIL eret_ignored_off: got %h want 94", pc_next); end
      eret = 1; #1;
      @(negedge clk); eret = 1; pc = 32'h48; #1;
      n_cmp++; if (in_isr !== 1'b0 || pc_next !== 32'h4C || flush !== 1'b0) begin n_bad++; $display("FAIL eret_outside: got %b %h fl%b want 0 4c fl0", in_isr, pc_next, flush); end
      $display("test_irq done");
   endtask

   task automatic test_halt();
      @(negedge clk); idle_inputs(); pc = 32'h80; halt_req = 1; irq = 3'b000; #1;
      n_cmp++; if (pc_en !== 1'b0) begin n_bad++; $display("FAIL halt_req_en: got %b want 0", pc_en); end
      @(negedge clk); halt_req = 0; irq = 3'b001; #1;
      n_cmp++; if (halted !== 1'b1 || pc_en !== 1'b0 || pc_next !== 32'h80) begin n_bad++; $display("FAIL halted: got h%b en%b %h want h1 en0 80", halted, pc_en, pc_next); end
      @(negedge clk); irq = 3'b000; #1;
      n_cmp++; if (halted !== 1'b1 || pc_en !== 1'b0 || flush !== 1'b0 || in_isr !== 1'b0) begin n_bad++; $display("FAIL halt_no_irq: got h%b en%b fl%b i%b want 1000", halted, pc_en, flush, in_isr); end
      go = 1; #1;
      n_cmp++; if (pc_next !== 32'h84 || pc_en !== 1'b1) begin n_bad++; $display("FAIL go: got %h en%b want 84 en1", pc_next, pc_en); end
      @(negedge clk); go = 0; pc = 32'h84; #1;
      n_cmp++; if (halted !== 1'b0 || pc_next !== 32'h800 || flush !== 1'b1) begin n_bad++; $display("FAIL post_halt_vec: got h%b %h want h0 800", halted, pc_next); end
      @(negedge clk); pc = 32'h800; #1;
      n_cmp++; if (epc !== 32'h88 || isr_src !== 2'd0 || in_isr !== 1'b1) begin n_bad++; $display("FAIL post_halt_epc: got %h %0d %b want 88 0 1", epc, isr_src, in_isr); end
      $display("test_halt done");
   endtask

   task automatic test_async_reset();
      @(negedge clk); irq = 3'b100; pc = 32'h804;
      @(posedge clk); #2; irq = 3'b000; rst = 1; #1;
      n_cmp++; if (in_isr !== 1'b0 || epc !== 32'h0 || halted !== 1'b0) begin n_bad++; $display("FAIL async_rst: got %b %h %b want 0 0 0", in_isr, epc, halted); end
      n_cmp++; if (pc_next !== 32'h0 || pc_en !== 1'b0) begin n_bad++; $display("FAIL async_rst_out: got %h en%b want 0 en0", pc_next, pc_en); end
      #1 rst = 0;
      @(negedge clk); pc = 32'h10; #1;
      n_cmp++; if (pc_next !== 32'h14 || flush !== 1'b0) begin n_bad++; $display("FAIL pending_lost: got %h fl%b want 14 fl0", pc_next, flush); end
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         rst           = ($urandom_range(99) < 2);
         stall         = ($urandom_range(99) < 15);
         halt_req      = ($urandom_range(99) < 5);
         go            = ($urandom_range(99) < 30);
         eret          = ($urandom_range(99) < 20);
         jump          = ($urandom_range(99) < 15);
         branch_taken  = ($urandom_range(99) < 20);
         irq           = ($urandom_range(99) < 15) ? 3'($urandom) : 3'b000;
         pc            = ($urandom_range(99) < 5) ? 32'hFFFF_FFFC : {$urandom()} & 32'hFFFF_FFFC;
         jump_target   = {$urandom()} & 32'hFFFF_FFFC;
         branch_target = {$urandom()} & 32'hFFFF_FFFC;
         #1;
         model_eval();
         if (exp_next_chk) begin
            n_cmp++; if (pc_next !== exp_next) begin n_bad++; $display("FAIL rnd_next[%0d]: got %h want %h", i, pc_next, exp_next); end
         end
         n_cmp++; if (pc_en !== exp_en || flush !== exp_fl) begin n_bad++; $display("FAIL rnd_en_fl[%0d]: got %b%b want %b%b", i, pc_en, flush, exp_en, exp_fl); end
         n_cmp++; if (halted !== (m_halted && !rst)) begin n_bad++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, halted, m_halted && !rst); end
         n_cmp++; if (in_isr !== m_in_isr || epc !== m_epc || isr_src !== 2'(m_src)) begin n_bad++; $display("FAIL rnd_isr[%0d]: got %b %h %0d want %b %h %0d", i, in_isr, epc, isr_src, m_in_isr, m_epc, m_src); end
         #2 rst = 0;
      end
      $display("test_random done");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_redirect();
      test_irq();
      test_halt();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
